// File: rtl/axi4_lite_rd_router.sv
// AXI4-Lite read-channel router: one master, SLAVE_NUM slaves, base/mask decode, local DECERR on miss.
// Optional saturating DECERR counter when AXIL_RD_DECERR_CNT_EN is defined.
package axi4_lite_addr_map_package;
  localparam int SLAVE_NUM  = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  // Slave 0: 0x0000_0000-0x0000_00FF, slave 1: 0x0000_0100-0x0000_01FF
  localparam logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = {32'h0000_0100, 32'h0000_0000};
  localparam logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00};
endpackage

module axi4_lite_rd_router #(
  parameter int SLAVE_NUM  = axi4_lite_addr_map_package::SLAVE_NUM,
  parameter int ADDR_WIDTH = axi4_lite_addr_map_package::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4_lite_addr_map_package::DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_arvalid,
  output logic                            s_arready,
  input  logic [ADDR_WIDTH-1:0]           s_araddr,
  input  logic [2:0]                      s_arprot,
  output logic                            s_rvalid,
  input  logic                            s_rready,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic [1:0]                      s_rresp,
  output logic [SLAVE_NUM-1:0]            m_arvalid,
  input  logic [SLAVE_NUM-1:0]            m_arready,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [2:0]                      m_arprot,
  input  logic [SLAVE_NUM-1:0]            m_rvalid,
  output logic [SLAVE_NUM-1:0]            m_rready,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] m_rdata,
`ifdef AXIL_RD_DECERR_CNT_EN
  input  logic [SLAVE_NUM*2-1:0]          m_rresp,
  input  logic                            decerr_cnt_clr,
  output logic [15:0]                     decerr_cnt
`else
  input  logic [SLAVE_NUM*2-1:0]          m_rresp
`endif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DECERR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              prot_q, prot_d;
  logic [SLAVE_NUM-1:0]    sel_q, sel_d;
  logic [SLAVE_NUM-1:0]    hit, dec_sel;
  logic                    sel_rvalid;

  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_dec
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(axi4_lite_addr_map_package::SLAVE_BASE_ADDR[i]);
    localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(axi4_lite_addr_map_package::SLAVE_ADDR_MASK[i]);
    assign hit[i] = (s_araddr & MASK) == (BASE & MASK);
  end

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    dec_sel = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
  end

  assign sel_rvalid = |(m_rvalid & sel_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      prot_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    prot_d  = prot_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (s_arvalid) begin
        addr_d  = s_araddr;
        prot_d  = s_arprot;
        sel_d   = dec_sel;
        state_d = (|dec_sel) ? ADDR : DECERR;
      end
      ADDR:    if (|(m_arready & sel_q)) state_d = DATA;
      DATA:    if (sel_rvalid && s_rready) state_d = IDLE;
      DECERR:  if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_araddr = addr_q;
  assign m_arprot = prot_q;

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    m_arvalid = '0;
    m_rready  = '0;
    case (state_q)
      IDLE: s_arready = 1'b1;
      ADDR: m_arvalid = sel_q;
      DATA: begin
        s_rvalid = sel_rvalid;
        m_rready = sel_q & {SLAVE_NUM{s_rready}};
        for (int i = 0; i < SLAVE_NUM; i++) begin
          if (sel_q[i]) begin
            s_rdata = m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_rresp = m_rresp[i*2 +: 2];
          end
        end
      end
      DECERR: begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
      end
      default: ;
    endcase
  end

`ifdef AXIL_RD_DECERR_CNT_EN
  logic [15:0] decerr_cnt_q, decerr_cnt_d;

  always_comb begin
    decerr_cnt_d = decerr_cnt_q;
    if (decerr_cnt_clr)
      decerr_cnt_d = '0;
    else if (state_q == DECERR && s_rready && decerr_cnt_q != 16'hFFFF)
      decerr_cnt_d = decerr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) decerr_cnt_q <= '0;
    else        decerr_cnt_q <= decerr_cnt_d;
  end

  assign decerr_cnt = decerr_cnt_q;
`endif

endmodule

// File: tb/tb_axi4_lite_rd_router.sv
// Scoreboard bench for axi4_lite_rd_router: behavioural slaves, directed reads, R-beat monitor.
module tb_axi4_lite_rd_router;
  localparam int SN = 2, AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr, m_araddr;
  logic [2:0] s_arprot, m_arprot;
  logic [DW-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic [SN-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [SN*DW-1:0] m_rdata;
  logic [SN*2-1:0] m_rresp;
`ifdef AXIL_RD_DECERR_CNT_EN
  logic decerr_cnt_clr;
  logic [15:0] decerr_cnt;
`endif

  always #5 clk = ~clk;

  axi4_lite_rd_router dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
`ifdef AXIL_RD_DECERR_CNT_EN
    .m_rresp(m_rresp), .decerr_cnt_clr(decerr_cnt_clr), .decerr_cnt(decerr_cnt)
`else
    .m_rresp(m_rresp)
`endif
  );

  int tests = 0, fails = 0, cyc = 0;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } exp_t;
  exp_t sb_q[$];
  logic [SN-1:0] seen_arv, seen_rrdy;
  logic [AW-1:0] exp_addr;
  int ar_delay[SN];
  logic [DW-1:0] sd[SN];
  logic [1:0] sr[SN];
  int acc_edge, rhs_edge;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Behavioural slaves: arready after ar_delay cycles of arvalid, one R beat after the AR handshake.
  initial begin
    int wcnt[SN];
    logic [SN-1:0] arv, arh, rh;
    logic rs;
    m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
    for (int i = 0; i < SN; i++) wcnt[i] = 0;
    forever begin
      @(negedge clk);
      arv = m_arvalid; arh = m_arvalid & m_arready; rh = m_rvalid & m_rready; rs = rst_n;
      @(posedge clk); #1;
      for (int i = 0; i < SN; i++) begin
        if (!rs) begin
          m_arready[i] = 1'b0; m_rvalid[i] = 1'b0; wcnt[i] = 0;
        end else begin
          if (arh[i]) begin
            m_arready[i] = 1'b0; m_rvalid[i] = 1'b1; wcnt[i] = 0;
            m_rdata[i*DW +: DW] = sd[i]; m_rresp[i*2 +: 2] = sr[i];
          end else if (arv[i] && !m_arready[i]) begin
            if (wcnt[i] >= ar_delay[i]) m_arready[i] = 1'b1;
            else wcnt[i]++;
          end
          if (rh[i]) begin m_rvalid[i] = 1'b0; m_rdata[i*DW +: DW] = '0; end
        end
      end
    end
  end

  // Monitor: AR-channel protocol checks and scoreboard pop on every R handshake.
  initial begin
    logic [SN-1:0] prev_arv, prev_arr;
    exp_t e;
    prev_arv = '0; prev_arr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_arv = '0;
      end else begin
        seen_arv  = seen_arv | m_arvalid;
        seen_rrdy = seen_rrdy | m_rready;
        if (m_arvalid != '0) begin
          check("arvalid_onehot", 64'($onehot(m_arvalid)), 64'd1);
          check("araddr", 64'(m_araddr), 64'(exp_addr));
        end
        if (prev_arv != '0 && (prev_arv & prev_arr) == '0)
          check("arvalid_hold", 64'(m_arvalid), 64'(prev_arv));
        if (s_rvalid && s_rready) begin
          if (sb_q.size() == 0) check("unexpected_r", 64'd1, 64'd0);
          else begin
            e = sb_q.pop_front();
            check("rdata", 64'(s_rdata), 64'(e.data));
            check("rresp", 64'(s_rresp), 64'(e.resp));
          end
        end
        prev_arv = m_arvalid; prev_arr = m_arready;
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] ed, input logic [1:0] er,
                         input int rdly, input bit bp, output int lat);
    int n, c_acc, lowcnt;
    sb_q.push_back('{data: ed, resp: er});
    exp_addr = addr;
    s_araddr = addr; s_arprot = 3'b010; s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready && n < 100);
    if (!s_arready) check("ar_accept_timeout", 64'd1, 64'd0);
    c_acc = cyc; acc_edge = cyc + 1;
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_araddr = '0;
    if (rdly == 0) s_rready = 1'b1;
    n = 0; lat = -1; lowcnt = 0;
    forever begin
      @(negedge clk); n++;
      if (s_rvalid && lat < 0) lat = cyc - c_acc;
      if (s_rvalid && s_rready) break;
      if (n > 200) begin check("r_timeout", 64'd1, 64'd0); sb_q.delete(); break; end
      if (s_rvalid) begin
        if (bp) begin
          check("bp_m_rready", 64'(m_rready), 64'd0);
          check("bp_rdata_stable", 64'(s_rdata), 64'(ed));
        end
        lowcnt++;
        if (lowcnt >= rdly) begin @(posedge clk); #1; s_rready = 1'b1; end
      end
    end
    rhs_edge = cyc + 1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  int lat, n;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0; s_rready = 1'b0;
    seen_arv = '0; seen_rrdy = '0; exp_addr = '0;
`ifdef AXIL_RD_DECERR_CNT_EN
    decerr_cnt_clr = 1'b0;
`endif
    for (int i = 0; i < SN; i++) begin ar_delay[i] = 0; sd[i] = '0; sr[i] = 2'b00; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_arready", 64'(s_arready), 64'd1);
    check("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_m_rready", 64'(m_rready), 64'd0);
    check("rst_s_rdata", 64'(s_rdata), 64'd0);
`ifdef AXIL_RD_DECERR_CNT_EN
    check("rst_decerr_cnt", 64'(decerr_cnt), 64'd0);
`endif
    @(posedge clk); #1;

    // Slave 0 hit with ARREADY delay
    ar_delay[0] = 2; sd[0] = 32'hDEADBEEF; sr[0] = 2'b00;
    seen_arv = '0; seen_rrdy = '0;
    do_read(32'h0000_0010, 32'hDEADBEEF, 2'b00, 0, 1'b0, lat);
    check("t1_seen_arvalid", 64'(seen_arv), 64'b01);

    // Slave 1 hit, SLVERR passed through
    ar_delay[1] = 0; sd[1] = 32'h12345678; sr[1] = 2'b10;
    seen_arv = '0; seen_rrdy = '0;
    do_read(32'h0000_0100, 32'h12345678, 2'b10, 0, 1'b0, lat);
    check("t2_seen_arvalid", 64'(seen_arv), 64'b10);

    // Miss -> local DECERR one cycle after accept, slaves untouched
    seen_arv = '0; seen_rrdy = '0;
    do_read(32'h0001_0000, 32'h0, 2'b11, 0, 1'b0, lat);
    check("t3_decerr_latency", 64'(lat), 64'd1);
    check("t3_seen_arvalid", 64'(seen_arv), 64'd0);
    check("t3_seen_rready", 64'(seen_rrdy), 64'd0);
`ifdef AXIL_RD_DECERR_CNT_EN
    check("t3_decerr_cnt", 64'(decerr_cnt), 64'd1);
    decerr_cnt_clr = 1'b1;
    @(posedge clk); #1 decerr_cnt_clr = 1'b0;
    check("t3_decerr_clr", 64'(decerr_cnt), 64'd0);
`endif

    // R backpressure: s_rready low for 5 cycles with rvalid up
    ar_delay[0] = 0; sd[0] = 32'hCAFE_0001; sr[0] = 2'b00;
    do_read(32'h0000_0010, 32'hCAFE_0001, 2'b00, 5, 1'b1, lat);

    // Reset while in ADDR
    ar_delay[0] = 50;
    exp_addr = 32'h0000_0020;
    s_araddr = 32'h0000_0020; s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready && n < 100);
    @(posedge clk); #1 s_arvalid = 1'b0;
    @(negedge clk);
    check("t5_in_addr", 64'(m_arvalid), 64'b01);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("t5_rst_s_arready", 64'(s_arready), 64'd1);
    @(posedge clk); #1;
    ar_delay[0] = 0; sd[0] = 32'h0000_0020; sr[0] = 2'b00;
    do_read(32'h0000_0020, 32'h0000_0020, 2'b00, 0, 1'b0, lat);

    // Back-to-back: slave 0 then slave 1
    sd[0] = 32'hAAAA_0000; sd[1] = 32'hBBBB_0104; sr[1] = 2'b00;
    seen_arv = '0;
    do_read(32'h0000_0000, 32'hAAAA_0000, 2'b00, 0, 1'b0, lat);
    n = rhs_edge;
    do_read(32'h0000_0104, 32'hBBBB_0104, 2'b00, 0, 1'b0, lat);
    check("t6_gap_ge_1", 64'((acc_edge - n) >= 1), 64'd1);
    check("t6_seen_arvalid", 64'(seen_arv), 64'b11);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_lite_rd_router.md
Name: axi4_lite_rd_router

Overview:
- 1-master-to-SLAVE_NUM-slave AXI4-Lite read-channel router; sits between the CPU data-side AXI4-Lite master port and the memory slaves.
- Decodes each AR address against the base/mask table in axi4_lite_addr_map_package and forwards the request to exactly one slave.
- Returns that slave's R beat to the master, or a local DECERR if no slave matches.
- One outstanding transaction at a time; the write channels are handled by a separate block.

Parameters:
- SLAVE_NUM, default axi4_lite_addr_map_package::SLAVE_NUM (2): number of slave ports.
- ADDR_WIDTH, default axi4_lite_addr_map_package::ADDR_WIDTH (32): address width.
- DATA_WIDTH, default axi4_lite_addr_map_package::DATA_WIDTH (32): data width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_arvalid  in  1  master AR valid.
- s_arready  out  1  master AR ready.
- s_araddr  in  ADDR_WIDTH  master AR address.
- s_arprot  in  3  master AR prot.
- s_rvalid  out  1  master R valid.
- s_rready  in  1  master R ready.
- s_rdata  out  DATA_WIDTH  master R data.
- s_rresp  out  2  master R response.
- m_arvalid  out  SLAVE_NUM  per-slave AR valid, one-hot or zero.
- m_arready  in  SLAVE_NUM  per-slave AR ready.
- m_araddr  out  ADDR_WIDTH  shared AR address, the latched request.
- m_arprot  out  3  shared AR prot, latched.
- m_rvalid  in  SLAVE_NUM  per-slave R valid.
- m_rready  out  SLAVE_NUM  per-slave R ready, one-hot or zero.
- m_rdata  in  SLAVE_NUM*DATA_WIDTH  slave i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_rresp  in  SLAVE_NUM*2  slave i response at bits [i*2 +: 2].

Behaviour:
- Decode: slave i hits when (addr & SLAVE_ADDR_MASK[i]) == (SLAVE_BASE_ADDR[i] & SLAVE_ADDR_MASK[i]).
  - Multiple hits: lowest index wins.
  - No hit: decode error.
- FSM states: IDLE, ADDR, DATA, DECERR. Reset puts the FSM in IDLE.
- Registers: addr_q, prot_q, sel_q (one-hot) all reset to 0.
- IDLE:
  - s_arready=1; all other outputs 0.
  - On s_arvalid&&s_arready: latch addr_q/prot_q, register the decode into sel_q.
  - Next state ADDR on a hit, DECERR on a miss.
- ADDR:
  - m_arvalid=sel_q; m_araddr=addr_q; m_arprot=prot_q; s_arready=0.
  - On |(m_arready & sel_q), go to DATA.
  - m_arvalid stays asserted until that handshake; never drops early.
- DATA:
  - s_rvalid = |(m_rvalid & sel_q); s_rdata/s_rresp mux from the selected slave; m_rready = sel_q & {SLAVE_NUM{s_rready}}.
  - This path is combinational: zero added latency on R.
  - On the selected slave's rvalid&&rready, go to IDLE.
  - Non-selected slaves' rvalid is ignored.
- DECERR:
  - s_rvalid=1, s_rresp=2'b11, s_rdata=0.
  - On s_rready, go to IDLE.
  - No slave sees any activity.
- Latency, hit path: 1 cycle AR accept, then the slave's AR/R latency, then a 1-cycle return to IDLE. Minimum 3 cycles per transaction.
- Latency, miss path: DECERR beat visible the cycle after AR accept.
- Back-to-back: a new AR is accepted only in IDLE, so there is at least 1 cycle between the R handshake and the next AR accept.
- s_rresp from a slave (OKAY/SLVERR) is passed through unmodified.
- m_araddr/m_arprot hold addr_q/prot_q in every state; they are valid only when m_arvalid is set.
- s_rdata/s_rresp are 0 in IDLE and ADDR.
- Reset mid-transaction: FSM returns to IDLE next edge and all valids drop. Slaves must be reset on the same rst_n.

Optional Feature:
- Macro: AXIL_RD_DECERR_CNT_EN.
- When defined:
  - Adds output port decerr_cnt (16 bits): saturating count of DECERR responses completed (s_rvalid&&s_rready in DECERR).
  - Sticks at 16'hFFFF; reset 0.
  - Adds input decerr_cnt_clr (1 bit): synchronous clear, with priority over increment in the same cycle.
- When undefined: neither port exists and the block has no counter logic.

Test Plan:
- Read 0x0000_0010, slave 0 returns 0xDEADBEEF/OKAY after 2-cycle ARREADY delay:
  - m_arvalid=2'b01 held through the delay; s_rdata=0xDEADBEEF, s_rresp=2'b00; m_arvalid[1] never asserted.
- Read 0x0000_0100:
  - Only slave 1 selected (m_arvalid=2'b10); slave 1 data 0x12345678/SLVERR appears as s_rdata=0x12345678, s_rresp=2'b10.
- Read 0x0001_0000 (no match):
  - s_rvalid the cycle after AR accept, s_rresp=2'b11, s_rdata=0; m_arvalid stays 0.
  - With AXIL_RD_DECERR_CNT_EN, decerr_cnt increments 0→1.
- R backpressure: s_rready held low 5 cycles while slave 0 asserts rvalid:
  - m_rready[0]=0 for those cycles; s_rvalid/s_rdata stable; single beat completes when s_rready rises.
- Assert rst_n=0 for one cycle while in ADDR:
  - Next cycle m_arvalid=0, s_arready=1 (IDLE); the following read to 0x0000_0020 completes normally.
- Back-to-back reads 0x0000_0000 then 0x0000_0104:
  - Second AR accepted no earlier than 1 cycle after the first R handshake; routed to slave 0 then slave 1 respectively.
